sna_response_packetizer: RTL and testbench
==========================================

SNA_RESPONSE_PACKETIZER -- requirements
Module: sna_response_packetizer

Interface
REQ-001 SHALL have parameter FLIT_W, default 37, NoC flit width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI4-Lite read-data width; FLIT_W >= DATA_W+4 is required.
REQ-003 SHALL have parameter NUM_VC, default 8, number of virtual channels.
REQ-004 SHALL have port clk  in  1  the single clock.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports header, tail  in  FLIT_W  preformed header and tail flits from the request side.
REQ-007 SHALL have ports rvalid, rdata[DATA_W], rresp[2]  in, and rready  out  1: the AXI4-Lite R channel.
REQ-008 SHALL have ports bvalid, bresp[2]  in, and bready  out  1: the AXI4-Lite B channel.
REQ-009 SHALL have ports is_allocatable, is_on_off  in  NUM_VC  per-VC free and on/off flow-control flags.
REQ-010 SHALL have ports noc_data  out  FLIT_W, is_valid  out  1, and vc_id  out  $clog2(NUM_VC).

Function
REQ-011 SHALL use the states IDLE, HEAD, BODY and TAIL.
REQ-012 In IDLE, rready/bready SHALL be combinational: asserted only for the granted channel, only while valid is high and is_allocatable != 0.
REQ-013 On an R or B transfer (valid&ready), the block SHALL capture header, tail, rdata and resp, latch the lowest-index set bit of is_allocatable as vc_id, and go to HEAD.
REQ-014 In HEAD, BODY and TAIL, rready and bready SHALL be 0.
REQ-015 A flit SHALL be emitted only in a cycle where is_on_off[vc_id]=1: noc_data and is_valid=1 are registered, is_valid is high for exactly one cycle per flit, and the FSM stays put while is_on_off[vc_id]=0.
REQ-016 HEAD SHALL emit the captured header, then go to BODY for R and to TAIL for B.
REQ-017 BODY SHALL emit {2'b01, zero pad, rresp, rdata}, then go to TAIL.
REQ-018 TAIL SHALL emit the captured tail with bits [1:0] replaced by the captured resp, then go to IDLE.
REQ-019 is_valid SHALL be 0 in every cycle without an emission.
REQ-020 Latency SHALL be: handshake in cycle N gives the header earliest at N+1; R packets take 3 flits and B packets take 2.
REQ-021 Changes to is_allocatable after capture SHALL be ignored; vc_id SHALL hold until the tail has been emitted.
REQ-022 With rvalid and bvalid both high, arbitration SHALL follow REQ-026/027.
REQ-023 A new handshake SHALL be possible in the cycle after the tail is emitted; no back-to-back overlap is allowed.

Reset
REQ-024 While rst_n=0 at a clk edge: state becomes IDLE; noc_data, vc_id and the captured registers become 0; is_valid becomes 0.
REQ-025 Reset asserted mid-packet SHALL abort the packet with no further flits; rready and bready SHALL be 0 during reset.

Configuration
REQ-026 With SNA_RESP_RR_ARB_EN defined, R/B arbitration SHALL be round-robin: a 1-bit last-grant register, reset value B, so R wins the first tie; the grant alternates on ties.
REQ-027 With SNA_RESP_RR_ARB_EN undefined, R SHALL always win ties (fixed priority) and the last-grant register SHALL be absent.

Structure
REQ-028 A shared package sna_pkg SHALL hold the state enum, the flit-type constants (FLIT_BODY=2'b01), the AXI resp constants and the default parameter values.
REQ-029 A sub-module sna_vc_select SHALL be used: a combinational lowest-set-bit priority encoder giving vc index and any-free.

Verification
REQ-030 R single: is_allocatable=8'h0C, on_off=8'hFF, rvalid, rdata=32'hDEADBEEF, rresp=0 -> rready for 1 cycle, then flits header/body/tail on consecutive cycles, vc_id=2.
REQ-031 B single: bresp=2'b10, is_allocatable=8'h80 -> header, then tail[1:0]=2'b10, vc_id=7, no body.
REQ-032 Stall: on_off[vc]=0 for 5 cycles after the header -> no is_valid during the stall; body appears in the first cycle on_off returns to 1.
REQ-033 No VC: rvalid=1, is_allocatable=0 -> rready stays 0, FSM stays IDLE.
REQ-034 Tie: rvalid=bvalid=1 held -> with SNA_RESP_RR_ARB_EN the order is R,B,R,B; without it the order is R,R,R.
REQ-035 Reset mid-BODY: rst_n=0 for 1 cycle -> is_valid=0 next cycle, state IDLE, no tail emitted.

Source files
------------

// File: rtl/sna_response_packetizer_pkg.sv
// Shared definitions for the SNA response packetizer: FSM states, flit-type
// and AXI response encodings, arbitration grant encoding, default parameters.
package sna_pkg;

  localparam int FLIT_W_DEF = 37;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_VC_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2,
    TAIL = 2'd3
  } sna_state_e;

  // Flit type tag carried in the two MSBs of a body flit.
  localparam logic [1:0] FLIT_BODY = 2'b01;

  // AXI4-Lite response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    GRANT_R = 1'b0,
    GRANT_B = 1'b1
  } sna_grant_e;

endpackage

// File: rtl/sna_response_packetizer_if.sv
// Bundle of the AXI4-Lite R/B response channels, the request-side header and
// tail flits, the per-VC flow-control flags and the NoC flit output.
// The packetizer uses the slave modport; whoever feeds it uses master.
interface sna_response_packetizer_if #(
  parameter int FLIT_W = 37,
  parameter int DATA_W = 32,
  parameter int NUM_VC = 8
) ();

  localparam int VC_W = $clog2(NUM_VC);

  logic [FLIT_W-1:0] header;
  logic [FLIT_W-1:0] tail;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  logic [NUM_VC-1:0] is_allocatable;
  logic [NUM_VC-1:0] is_on_off;

  logic [FLIT_W-1:0] noc_data;
  logic              is_valid;
  logic [VC_W-1:0]   vc_id;

  modport slave (
    input  header, tail,
    input  rvalid, rdata, rresp,
    input  bvalid, bresp,
    input  is_allocatable, is_on_off,
    output rready, bready,
    output noc_data, is_valid, vc_id
  );

  modport master (
    output header, tail,
    output rvalid, rdata, rresp,
    output bvalid, bresp,
    output is_allocatable, is_on_off,
    input  rready, bready,
    input  noc_data, is_valid, vc_id
  );

endinterface

// File: rtl/sna_response_packetizer_vc_select.sv
// Lowest-index free virtual channel picker: pure combinational priority
// encoder returning the index of the lowest set request bit and whether any
// bit is set at all.
module sna_vc_select #(
  parameter int NUM_VC = 8,
  parameter int VC_W   = $clog2(NUM_VC)
) (
  input  logic [NUM_VC-1:0] req,
  output logic [VC_W-1:0]   idx,
  output logic              any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = VC_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sna_response_packetizer.sv
// SNA response packetizer: turns one AXI4-Lite read (R) or write (B)
// response into a NoC packet. R packets are header/body/tail, B packets are
// header/tail. Flits leave only while the chosen VC is switched on.
//
// Build option: SNA_RESP_RR_ARB_EN selects round-robin R/B arbitration on
// ties; without it R always wins.
//
// state | meaning
// IDLE  | waiting for an R or B handshake with at least one free VC
// HEAD  | emit captured header when the VC is on
// BODY  | emit read-data body flit (R only) when the VC is on
// TAIL  | emit captured tail with resp in bits [1:0], then back to IDLE
module sna_response_packetizer
  import sna_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_VC = NUM_VC_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sna_response_packetizer_if.slave  bus
);

  localparam int VC_W = $clog2(NUM_VC);

  sna_state_e        state;
  logic [FLIT_W-1:0] header_q;
  logic [FLIT_W-3:0] tail_hi_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        resp_q;
  logic              is_r_q;
  logic [VC_W-1:0]   vc_q;
  logic [FLIT_W-1:0] noc_q;
  logic              valid_q;

  logic [VC_W-1:0]   free_idx;
  logic              any_free;
  logic              prefer_r;
  logic              grant_r;
  logic              grant_b;
  logic              accept_ok;
  logic              rready_c;
  logic              bready_c;
  logic              r_xfer;
  logic              b_xfer;
  logic              vc_on;
  logic [FLIT_W-1:0] body_flit;
  logic [FLIT_W-1:0] tail_flit;

  sna_vc_select #(
    .NUM_VC (NUM_VC),
    .VC_W   (VC_W)
  ) u_vc_select (
    .req (bus.is_allocatable),
    .idx (free_idx),
    .any (any_free)
  );

`ifdef SNA_RESP_RR_ARB_EN
  sna_grant_e last_grant;

  // Remember who was served last so a tie goes to the other channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= GRANT_B;
    end else if (r_xfer) begin
      last_grant <= GRANT_R;
    end else if (b_xfer) begin
      last_grant <= GRANT_B;
    end
  end

  assign prefer_r = (last_grant == GRANT_B);
`else
  assign prefer_r = 1'b1;
`endif

  assign grant_r   = bus.rvalid && (!bus.bvalid || prefer_r);
  assign grant_b   = bus.bvalid && !grant_r;
  // Ready is withheld during reset so nothing is accepted that will be lost.
  assign accept_ok = rst_n && (state == IDLE) && any_free;
  assign rready_c  = accept_ok && grant_r;
  assign bready_c  = accept_ok && grant_b;
  assign r_xfer    = bus.rvalid && rready_c;
  assign b_xfer    = bus.bvalid && bready_c;
  assign vc_on     = bus.is_on_off[vc_q];

  // Body flit: type tag on top, resp and rdata at the bottom, zero between.
  always_comb begin
    body_flit                       = '0;
    body_flit[DATA_W-1:0]           = rdata_q;
    body_flit[DATA_W+1:DATA_W]      = resp_q;
    body_flit[FLIT_W-1:FLIT_W-2]    = FLIT_BODY;
  end

  assign tail_flit = {tail_hi_q, resp_q};

  // Packet sequencer: capture on handshake, then one flit per enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      header_q  <= '0;
      tail_hi_q <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      is_r_q    <= 1'b0;
      vc_q      <= '0;
      noc_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (r_xfer || b_xfer) begin
            header_q  <= bus.header;
            tail_hi_q <= bus.tail[FLIT_W-1:2];
            rdata_q   <= bus.rdata;
            resp_q    <= r_xfer ? bus.rresp : bus.bresp;
            is_r_q    <= r_xfer;
            vc_q      <= free_idx;
            state     <= HEAD;
          end
        end
        HEAD: begin
          if (vc_on) begin
            noc_q   <= header_q;
            valid_q <= 1'b1;
            state   <= is_r_q ? BODY : TAIL;
          end
        end
        BODY: begin
          if (vc_on) begin
            noc_q   <= body_flit;
            valid_q <= 1'b1;
            state   <= TAIL;
          end
        end
        TAIL: begin
          if (vc_on) begin
            noc_q   <= tail_flit;
            valid_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rready   = rready_c;
  assign bus.bready   = bready_c;
  assign bus.noc_data = noc_q;
  assign bus.is_valid = valid_q;
  assign bus.vc_id    = vc_q;

endmodule

// File: tb/tb_sna_response_packetizer.sv
// Scoreboard bench for the SNA response packetizer: directed scenarios then
// random traffic, checked against a packet-level reference model.
module tb_sna_response_packetizer;
  import sna_pkg::*;

  localparam int FLIT_W = FLIT_W_DEF;
  localparam int DATA_W = DATA_W_DEF;
  localparam int NUM_VC = NUM_VC_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sna_response_packetizer_if #(.FLIT_W(FLIT_W), .DATA_W(DATA_W), .NUM_VC(NUM_VC)) bus ();

  sna_response_packetizer #(.FLIT_W(FLIT_W), .DATA_W(DATA_W), .NUM_VC(NUM_VC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_busy = 1'b0;
  int m_left = 0;
  int m_vc = 0;
  bit m_last_b = 1'b1;
  bit m_exp_valid = 1'b0;
  logic [FLIT_W-1:0] exp_q[$];
  int exp_vc_q[$];

  bit log_en = 1'b0;
  bit dut_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [NUM_VC-1:0] v);
    for (int i = 0; i < NUM_VC; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit prefer_r();
`ifdef SNA_RESP_RR_ARB_EN
    return m_last_b;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void exp_ready(output bit er, output bit eb);
    bit can, gr;
    can = (rst_n === 1'b1) && !m_busy && (bus.is_allocatable != '0);
    gr  = bus.rvalid && (!bus.bvalid || prefer_r());
    er  = can && gr;
    eb  = can && bus.bvalid && !gr;
  endfunction

  // Model: at each edge, either count down an in-flight packet or accept one.
  always @(posedge clk) begin
    bit er, eb;
    logic [FLIT_W-1:0] f;
    logic [1:0] resp;
    if (rst_n !== 1'b1) begin
      m_busy = 1'b0;
      m_exp_valid = 1'b0;
      m_last_b = 1'b1;
      exp_q.delete();
      exp_vc_q.delete();
    end else begin
      exp_ready(er, eb);
      m_exp_valid = 1'b0;
      if (m_busy) begin
        if (bus.is_on_off[m_vc]) begin
          m_exp_valid = 1'b1;
          m_left--;
          if (m_left == 0) m_busy = 1'b0;
        end
      end else if (er || eb) begin
        m_vc   = lowest(bus.is_allocatable);
        m_busy = 1'b1;
        m_left = er ? 3 : 2;
        resp   = er ? bus.rresp : bus.bresp;
        exp_q.push_back(bus.header);
        exp_vc_q.push_back(m_vc);
        if (er) begin
          f = (FLIT_W'(1) << (FLIT_W - 2)) | (FLIT_W'(resp) << DATA_W) | FLIT_W'(bus.rdata);
          exp_q.push_back(f);
          exp_vc_q.push_back(m_vc);
        end
        f = ((bus.tail >> 2) << 2) | FLIT_W'(resp);
        exp_q.push_back(f);
        exp_vc_q.push_back(m_vc);
        m_last_b = eb;
      end
    end
  end

  // Monitor: compare handshakes, flit strobe and flit contents mid-cycle.
  always @(negedge clk) begin
    bit er, eb;
    exp_ready(er, eb);
    check("rready", bus.rready, er);
    check("bready", bus.bready, eb);
    check("is_valid", bus.is_valid, m_exp_valid);
    if (m_busy) check("vc_hold", bus.vc_id, m_vc);
    if (log_en) begin
      if (bus.rvalid && bus.rready) dut_log.push_back(1'b1);
      else if (bus.bvalid && bus.bready) dut_log.push_back(1'b0);
    end
    if (bus.is_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit actual=%0h required=none", bus.noc_data);
      end else begin
        check("noc_data", bus.noc_data, exp_q.pop_front());
        check("flit_vc", bus.vc_id, exp_vc_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.rvalid = 1'b0;
    bus.bvalid = 1'b0;
    bus.is_allocatable = '1;
    bus.is_on_off = '1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_order[$];
    bus.header = '0;
    bus.tail = '0;
    bus.rdata = '0;
    bus.rresp = '0;
    bus.bresp = '0;
    quiet();

    // reset values
    do_reset(3);
    check("rst_noc_data", bus.noc_data, 0);
    check("rst_vc_id", bus.vc_id, 0);
    check("rst_is_valid", bus.is_valid, 0);

    // single R packet on VC 2
    bus.header = FLIT_W'(37'h1_2345_6789);
    bus.tail = FLIT_W'(37'h0_ABCD_EF03);
    bus.is_allocatable = 8'h0C;
    bus.rvalid = 1'b1;
    bus.rdata = 32'hDEADBEEF;
    bus.rresp = RESP_OKAY;
    step();
    bus.rvalid = 1'b0;
    bus.is_allocatable = 8'h01;
    repeat (2) step();
    check("r_vc_id", bus.vc_id, 2);
    repeat (3) step();

    // single B packet on VC 7
    bus.header = FLIT_W'(37'h0_1111_2222);
    bus.tail = FLIT_W'(37'h1_3333_4444);
    bus.is_allocatable = 8'h80;
    bus.bvalid = 1'b1;
    bus.bresp = RESP_SLVERR;
    step();
    bus.bvalid = 1'b0;
    bus.is_allocatable = '1;
    repeat (2) step();
    check("b_vc_id", bus.vc_id, 7);
    repeat (2) step();

    // stall after header
    bus.is_allocatable = 8'h01;
    bus.rvalid = 1'b1;
    bus.rdata = 32'h0BAD_F00D;
    bus.rresp = RESP_EXOKAY;
    step();
    bus.rvalid = 1'b0;
    step();
    bus.is_on_off = 8'hFE;
    repeat (5) step();
    bus.is_on_off = '1;
    repeat (4) step();

    // no free VC: nothing accepted
    bus.is_allocatable = '0;
    bus.rvalid = 1'b1;
    repeat (5) step();
    check("novc_is_valid", bus.is_valid, 0);
    bus.rvalid = 1'b0;
    bus.is_allocatable = '1;
    step();

    // ties from a fresh reset
    do_reset(1);
    log_en = 1'b1;
    dut_log.delete();
    bus.rvalid = 1'b1;
    bus.bvalid = 1'b1;
    bus.rresp = RESP_DECERR;
    bus.bresp = RESP_OKAY;
    repeat (16) step();
    bus.rvalid = 1'b0;
    bus.bvalid = 1'b0;
    log_en = 1'b0;
    repeat (4) step();
`ifdef SNA_RESP_RR_ARB_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1};
`endif
    check("tie_count_ok", dut_log.size() >= exp_order.size(), 1);
    for (int i = 0; i < exp_order.size(); i++) begin
      if (i < dut_log.size()) check($sformatf("tie_grant_%0d", i), dut_log[i], exp_order[i]);
    end

    // reset in the middle of the body
    bus.rvalid = 1'b1;
    bus.rdata = 32'h5555_AAAA;
    step();
    bus.rvalid = 1'b0;
    step();
    bus.is_on_off = '0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.is_on_off = '1;
    check("midrst_is_valid", bus.is_valid, 0);
    repeat (6) step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.rvalid = 1'($urandom_range(0, 1));
      bus.bvalid = 1'($urandom_range(0, 1));
      bus.rdata = $urandom();
      bus.rresp = 2'($urandom_range(0, 3));
      bus.bresp = 2'($urandom_range(0, 3));
      bus.header = FLIT_W'({$urandom(), $urandom()});
      bus.tail = FLIT_W'({$urandom(), $urandom()});
      bus.is_allocatable = ($urandom_range(0, 4) == 0) ? '0 : NUM_VC'($urandom());
      bus.is_on_off = NUM_VC'($urandom() | $urandom());
      step();
    end

    // drain outstanding flits with a bounded wait
    quiet();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) step();
    check("drain_empty", exp_q.size(), 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
